// File: rtl/uart_pkg.sv
//------------------------------------------------------------------------------
// Module      : uart_pkg
// Description : Opcodes, response codes, FSM state encoding and small helpers
//               shared by the UART command responder.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

    localparam logic [7:0] OP_WR   = 8'h57;
    localparam logic [7:0] OP_RD   = 8'h52;
    localparam logic [7:0] RSP_OK  = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h3F;
    localparam logic [7:0] RSP_TO  = 8'h54;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GET_ADDR = 3'd1,
        ST_GET_DATA = 3'd2,
        ST_BUS_WR   = 3'd3,
        ST_BUS_RD   = 3'd4,
        ST_RD_WAIT  = 3'd5,
        ST_SEND     = 3'd6
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // An address byte is in range when no bit at or above aw is set.
    function automatic logic addr_in_range(input logic [7:0] a, input int aw);
        return (aw >= 8) || ((a >> aw) == 8'd0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_cmd_timer.sv
//------------------------------------------------------------------------------
// Module      : uart_cmd_timer
// Description : Inter-byte timeout counter; only instantiated by the responder
//               when UART_CMD_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_cmd_timer #(
    parameter int TIMEOUT_CYC = 100000,
    parameter int TO_W        = 17
) (
    input  logic clk,
    input  logic reset,
    input  logic i_run,
    input  logic i_clr,
    output logic o_expired
);

    logic [TO_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_run && !o_expired) begin
            r_cnt <= r_cnt + TO_W'(1);
        end
    end

    assign o_expired = (r_cnt == TO_W'(TIMEOUT_CYC - 1));

endmodule

`default_nettype wire

// File: rtl/uart_cmd_responder.sv
//------------------------------------------------------------------------------
// Module      : uart_cmd_responder
// Description : Pops 'W'/'R' command frames from the UART RX FIFO, performs the
//               register-bus access and pushes a one-byte response to TX.
//               Optional inter-byte timeout: define UART_CMD_TIMEOUT_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_cmd_responder
    import uart_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter int TIMEOUT_CYC = 100000,
    parameter int TO_W        = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_empty,
    input  logic [7:0]        r_data,
    output logic              rd_uart,
    input  logic              tx_full,
    output logic [7:0]        w_data,
    output logic              wr_uart,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [7:0]        reg_rdata,
    output logic              busy,
    output logic [7:0]        err_cnt
);

    state_t            r_state;
    logic [7:0]        r_resp;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_wdata;
    logic [7:0]        r_err_cnt;
    logic              r_is_wr;
    logic              r_bad;
    logic              w_fetch;
    logic              w_addr_ok;

    assign w_fetch   = (r_state == ST_IDLE) || (r_state == ST_GET_ADDR) ||
                       (r_state == ST_GET_DATA);
    assign w_addr_ok = addr_in_range(r_data, ADDR_W);

`ifdef UART_CMD_TIMEOUT_EN
    logic w_to_run;
    logic w_to_clr;
    logic w_to_expired;

    // Only mid-frame waits are timed; IDLE and every pop restart the count.
    assign w_to_run = (r_state != ST_IDLE) && w_fetch && rx_empty;
    assign w_to_clr = !((r_state == ST_GET_ADDR) || (r_state == ST_GET_DATA)) || rd_uart;

    uart_cmd_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TO_W        (TO_W)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .i_run     (w_to_run),
        .i_clr     (w_to_clr),
        .o_expired (w_to_expired)
    );
`else
    logic w_unused_to;
    assign w_unused_to = ^{TIMEOUT_CYC[0], TO_W[0]};
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_resp    <= 8'h00;
            r_addr    <= '0;
            r_wdata   <= 8'h00;
            r_err_cnt <= 8'h00;
            r_is_wr   <= 1'b0;
            r_bad     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!rx_empty) begin
                        if (r_data == OP_WR || r_data == OP_RD) begin
                            r_is_wr <= (r_data == OP_WR);
                            r_state <= ST_GET_ADDR;
                        end else begin
                            r_resp    <= RSP_ERR;
                            r_err_cnt <= sat_inc8(r_err_cnt);
                            r_state   <= ST_SEND;
                        end
                    end
                end
                ST_GET_ADDR: begin
                    if (!rx_empty) begin
                        r_bad <= !w_addr_ok;
                        if (w_addr_ok) begin
                            r_addr <= r_data[ADDR_W-1:0];
                        end
                        // A bad write address still swallows its data byte.
                        if (r_is_wr) begin
                            r_state <= ST_GET_DATA;
                        end else if (w_addr_ok) begin
                            r_state <= ST_BUS_RD;
                        end else begin
                            r_resp    <= RSP_ERR;
                            r_err_cnt <= sat_inc8(r_err_cnt);
                            r_state   <= ST_SEND;
                        end
                    end
`ifdef UART_CMD_TIMEOUT_EN
                    else if (w_to_expired) begin
                        r_resp    <= RSP_TO;
                        r_err_cnt <= sat_inc8(r_err_cnt);
                        r_state   <= ST_SEND;
                    end
`endif
                end
                ST_GET_DATA: begin
                    if (!rx_empty) begin
                        if (!r_bad) begin
                            r_wdata <= r_data;
                            r_state <= ST_BUS_WR;
                        end else begin
                            r_resp    <= RSP_ERR;
                            r_err_cnt <= sat_inc8(r_err_cnt);
                            r_state   <= ST_SEND;
                        end
                    end
`ifdef UART_CMD_TIMEOUT_EN
                    else if (w_to_expired) begin
                        r_resp    <= RSP_TO;
                        r_err_cnt <= sat_inc8(r_err_cnt);
                        r_state   <= ST_SEND;
                    end
`endif
                end
                ST_BUS_WR: begin
                    r_resp  <= RSP_OK;
                    r_state <= ST_SEND;
                end
                ST_BUS_RD: begin
                    r_state <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    r_resp  <= reg_rdata;
                    r_state <= ST_SEND;
                end
                ST_SEND: begin
                    if (!tx_full) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Pop and push must coincide with the capturing/leaving cycle, so they
    // are decoded from the registered state rather than registered again.
    assign rd_uart   = w_fetch && !rx_empty;
    assign wr_uart   = (r_state == ST_SEND) && !tx_full;
    assign w_data    = r_resp;
    assign reg_we    = (r_state == ST_BUS_WR);
    assign reg_re    = (r_state == ST_BUS_RD);
    assign reg_addr  = r_addr;
    assign reg_wdata = r_wdata;
    assign busy      = (r_state != ST_IDLE);
    assign err_cnt   = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_responder.sv
//------------------------------------------------------------------------------
// Module      : tb_uart_cmd_responder
// Description : Directed, table-driven bench with RX/TX FIFO and register models.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_cmd_responder;

    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              rx_empty = 1'b1;
    logic [7:0]        r_data = 8'h00;
    logic              rd_uart;
    logic              tx_full = 1'b0;
    logic [7:0]        w_data;
    logic              wr_uart;
    logic [ADDR_W-1:0] reg_addr;
    logic [7:0]        reg_wdata;
    logic              reg_we;
    logic              reg_re;
    logic [7:0]        reg_rdata = 8'hEE;
    logic              busy;
    logic [7:0]        err_cnt;

    uart_cmd_responder #(
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CYC (50),
        .TO_W        (17)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_empty  (rx_empty),
        .r_data    (r_data),
        .rd_uart   (rd_uart),
        .tx_full   (tx_full),
        .w_data    (w_data),
        .wr_uart   (wr_uart),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .busy      (busy),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         n;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        logic [7:0] resp;
        int         we;
        int         re;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] err;
        int         lat;
    } vec_t;

    vec_t       vecs[8];
    logic [7:0] mem[16];
    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    int         n_pass = 0;
    int         n_total = 0;
    int         cyc = 0;
    int         we_cnt, re_cnt, pop_viol;
    int         pop_cyc, wr_cyc;
    bit         frame_popped, do_pop, rd_pend;
    logic [3:0] rd_addr, last_addr;
    logic [7:0] last_wdata;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic rx_update();
        rx_empty = (rx_q.size() == 0);
        r_data   = rx_empty ? 8'h00 : rx_q[0];
    endtask

    // Observe the cycle at the falling edge, then apply FIFO/register effects
    // just after the rising edge that consumed them.
    task automatic step();
        @(negedge clk);
        if (rd_uart) begin
            if (rx_q.size() == 0) pop_viol++;
            else begin
                do_pop = 1'b1;
                if (!frame_popped) begin
                    frame_popped = 1'b1;
                    pop_cyc = cyc;
                end
            end
        end
        if (wr_uart) begin
            tx_q.push_back(w_data);
            wr_cyc = cyc;
        end
        if (reg_we) begin
            we_cnt++;
            mem[reg_addr] = reg_wdata;
            last_addr  = reg_addr;
            last_wdata = reg_wdata;
        end
        if (reg_re) begin
            re_cnt++;
            last_addr = reg_addr;
            rd_pend   = 1'b1;
            rd_addr   = reg_addr;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (do_pop) begin
            rx_q.delete(0);
            do_pop = 1'b0;
        end
        reg_rdata = rd_pend ? mem[rd_addr] : 8'hEE;
        rd_pend   = 1'b0;
        rx_update();
    endtask

    task automatic clear_frame();
        tx_q.delete();
        we_cnt = 0;
        re_cnt = 0;
        frame_popped = 1'b0;
        pop_cyc = 0;
        wr_cyc  = 0;
    endtask

    task automatic run_frame(input int n, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2);
        int k;
        clear_frame();
        rx_q.push_back(b0);
        if (n > 1) rx_q.push_back(b1);
        if (n > 2) rx_q.push_back(b2);
        rx_update();
        k = 0;
        while (tx_q.size() == 0 && k < 60) begin
            step();
            k++;
        end
        chk("frame_done", 32'(tx_q.size() > 0), 32'd1);
        repeat (3) step();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
        pop_viol = 0;
        do_pop = 1'b0;
        rd_pend = 1'b0;
        clear_frame();

        //                n  b0     b1     b2     resp   we re addr  wdata  err   lat
        vecs[0] = '{3, 8'h57, 8'h03, 8'hA5, 8'h4B, 1, 0, 4'h3, 8'hA5, 8'h00, 0};
        vecs[1] = '{2, 8'h52, 8'h03, 8'h00, 8'hA5, 0, 1, 4'h3, 8'h00, 8'h00, 4};
        vecs[2] = '{1, 8'h41, 8'h00, 8'h00, 8'h3F, 0, 0, 4'h0, 8'h00, 8'h01, 0};
        vecs[3] = '{3, 8'h57, 8'h20, 8'h11, 8'h3F, 0, 0, 4'h0, 8'h00, 8'h02, 0};
        vecs[4] = '{2, 8'h52, 8'h1F, 8'h00, 8'h3F, 0, 0, 4'h0, 8'h00, 8'h03, 0};
        vecs[5] = '{2, 8'h52, 8'h00, 8'h00, 8'h10, 0, 1, 4'h0, 8'h00, 8'h03, 4};
        vecs[6] = '{3, 8'h57, 8'h0F, 8'hFF, 8'h4B, 1, 0, 4'hF, 8'hFF, 8'h03, 0};
        vecs[7] = '{2, 8'h52, 8'h0F, 8'h00, 8'hFF, 0, 1, 4'hF, 8'h00, 8'h03, 4};

        repeat (2) step();
        chk("rst_wr_uart", 32'(wr_uart), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_strobes", 32'({reg_we, reg_re, rd_uart}), 32'd0);
        chk("rst_bus_regs", 32'({w_data, reg_wdata, reg_addr}), 32'd0);
        reset = 1'b1;
        step();

        for (int v = 0; v < 8; v++) begin
            run_frame(vecs[v].n, vecs[v].b0, vecs[v].b1, vecs[v].b2);
            chk($sformatf("v%0d_tx_count", v), 32'(tx_q.size()), 32'd1);
            if (tx_q.size() > 0) chk($sformatf("v%0d_resp", v), 32'(tx_q[0]), 32'(vecs[v].resp));
            chk($sformatf("v%0d_we", v), 32'(we_cnt), 32'(vecs[v].we));
            chk($sformatf("v%0d_re", v), 32'(re_cnt), 32'(vecs[v].re));
            if (vecs[v].we + vecs[v].re > 0)
                chk($sformatf("v%0d_addr", v), 32'(last_addr), 32'(vecs[v].addr));
            if (vecs[v].we > 0)
                chk($sformatf("v%0d_wdata", v), 32'(last_wdata), 32'(vecs[v].wdata));
            chk($sformatf("v%0d_err_cnt", v), 32'(err_cnt), 32'(vecs[v].err));
            chk($sformatf("v%0d_busy", v), 32'(busy), 32'd0);
            chk($sformatf("v%0d_rx_drained", v), 32'(rx_q.size()), 32'd0);
            if (vecs[v].lat > 0)
                chk($sformatf("v%0d_latency", v), 32'(wr_cyc - pop_cyc), 32'(vecs[v].lat));
        end

        // TX back-pressure: response held, trailing byte left in the RX FIFO.
        clear_frame();
        tx_full = 1'b1;
        rx_q.push_back(8'h52);
        rx_q.push_back(8'h02);
        rx_q.push_back(8'h41);
        rx_update();
        repeat (20) step();
        chk("stall_no_push", 32'(tx_q.size()), 32'd0);
        chk("stall_busy", 32'(busy), 32'd1);
        chk("stall_rx_left", 32'(rx_q.size()), 32'd1);
        chk("stall_re", 32'(re_cnt), 32'd1);
        tx_full = 1'b0;
        step();
        chk("release_push", 32'(tx_q.size()), 32'd1);
        if (tx_q.size() > 0) chk("release_data", 32'(tx_q[0]), 32'h12);
        repeat (6) step();
        chk("after_stall_tx", 32'(tx_q.size()), 32'd2);
        if (tx_q.size() > 1) chk("after_stall_resp", 32'(tx_q[1]), 32'h3F);
        chk("after_stall_err", 32'(err_cnt), 32'd4);

        // err_cnt saturation.
        for (int f = 0; f < 260; f++) begin
            clear_frame();
            rx_q.push_back(8'h00);
            rx_update();
            for (int k = 0; k < 10 && tx_q.size() == 0; k++) step();
        end
        step();
        chk("err_saturate", 32'(err_cnt), 32'hFF);

        // Reset in the middle of a write frame.
        clear_frame();
        rx_q.push_back(8'h57);
        rx_q.push_back(8'h05);
        rx_update();
        repeat (2) step();
        chk("mid_frame_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        repeat (2) step();
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_err", 32'(err_cnt), 32'd0);
        reset = 1'b1;
        step();
        chk("no_stray_resp", 32'(tx_q.size()), 32'd0);
        run_frame(2, 8'h52, 8'h05, 8'h00);
        chk("post_rst_tx", 32'(tx_q.size()), 32'd1);
        if (tx_q.size() > 0) chk("post_rst_data", 32'(tx_q[0]), 32'h15);
        chk("post_rst_no_we", 32'(we_cnt), 32'd0);
        chk("post_rst_err", 32'(err_cnt), 32'd0);

`ifdef UART_CMD_TIMEOUT_EN
        clear_frame();
        rx_q.push_back(8'h57);
        rx_update();
        for (int k = 0; k < 120 && tx_q.size() == 0; k++) step();
        chk("to_tx", 32'(tx_q.size()), 32'd1);
        if (tx_q.size() > 0) chk("to_resp", 32'(tx_q[0]), 32'h54);
        chk("to_latency", 32'(wr_cyc - pop_cyc), 32'd51);
        step();
        chk("to_err", 32'(err_cnt), 32'd1);
        run_frame(2, 8'h52, 8'h00, 8'h00);
        if (tx_q.size() > 0) chk("to_next_resp", 32'(tx_q[0]), 32'h10);
`endif

        chk("no_pop_when_empty", 32'(pop_viol), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
